// File: rtl/mcu_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, ALU op
// codes, FSM states, datapath mux selects and the bundled control word.
package mcu_ctrl_pkg;

  // Opcode field IR[31:26]
  localparam logic [5:0] OP_R_TYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_J      = 6'b000010;

  // alu_op_main encoding, shared with the ALU control unit
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // FSM state encodings (exported on state_dbg)
  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_RTEXEC   = 4'd7,
    S_ALUWB    = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_BEQ      = 4'd11,
    S_JUMP     = 4'd12,
    S_TRAP     = 4'd13
  } state_e;

  // All datapath control outputs as one word so a single idle value
  // can default or squash them together.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op_main;
    logic       instr_done;
  } ctl_t;

  localparam ctl_t CTL_IDLE = 17'b0;

  // States that drive the shared memory port and may wait on mem_ready
  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mem_wait_watchdog.sv
// Counts wait cycles spent in a memory state and flags a timeout when the
// limit is reached without an acknowledge. A limit of 0 disables it.
module mem_wait_watchdog #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic in_mem_i,
  input  logic ack_i,
  output logic trap_o,
  output logic mem_timeout_o
);

  // Counter only needs to hold 0..MEM_TIMEOUT-1; the trap fires on the
  // wait cycle that would take it to MEM_TIMEOUT.
  localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : {CW{1'b0}};

  logic [CW-1:0] wait_q, wait_d;
  logic          flag_q, flag_d;

  // Trap decision and next counter/flag values; an ack in the limit cycle wins
  always_comb begin
    trap_o = 1'b0;
    wait_d = wait_q;
    flag_d = flag_q;
    if ((MEM_TIMEOUT > 0) && in_mem_i && !ack_i && (wait_q == LIMIT)) begin
      trap_o = 1'b1;
    end else begin
      trap_o = 1'b0;
    end
    if (!in_mem_i || ack_i) begin
      wait_d = {CW{1'b0}};
    end else if (wait_q != LIMIT) begin
      wait_d = wait_q + CW'(1);
    end else begin
      wait_d = wait_q;
    end
    flag_d = flag_q | trap_o;
  end

  // Wait counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= {CW{1'b0}};
      flag_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      flag_q <= flag_d;
    end
  end

  assign mem_timeout_o = flag_q;

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences each instruction over 3-5 cycles,
// shares one memory port, traps illegal opcodes and memory timeouts, and
// counts retired instructions.
module multicycle_control
  import mcu_ctrl_pkg::*;
#(
  parameter bit          USE_MEM_READY   = 1'b1,
  parameter int unsigned MEM_TIMEOUT     = 15,
  parameter bit          ENABLE_JUMP     = 1'b1,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op_main,
  output logic             instr_done,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state_dbg
);

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q, count_d;
  ctl_t             ctl_s;
  logic             ack_s;
  logic             in_mem_s;
  logic             wd_trap_s;
  logic             bad_op_s;
  logic             illegal_set_s;

  assign ack_s    = USE_MEM_READY ? mem_ready : 1'b1;
  assign in_mem_s = is_mem_state(state_q);

  mem_wait_watchdog #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_watchdog (
    .clk           (clk),
    .rst           (rst),
    .in_mem_i      (in_mem_s),
    .ack_i         (ack_s),
    .trap_o        (wd_trap_s),
    .mem_timeout_o (mem_timeout)
  );

  // Next-state and control-word decode (Mealy on ack for memory states)
  always_comb begin
    ctl_s         = CTL_IDLE;
    state_d       = state_q;
    bad_op_s      = 1'b0;
    illegal_set_s = 1'b0;
    case (state_q)
      S_RESET: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        ctl_s.mem_read    = 1'b1;
        ctl_s.alu_src_b   = SRC_B_FOUR;
        ctl_s.alu_op_main = ALU_OP_ADD;
        ctl_s.pc_source   = PC_SRC_ALU;
        ctl_s.ir_write    = ack_s;
        ctl_s.pc_write    = ack_s;
        if (ack_s) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        // Branch target computed speculatively into ALUOut
        ctl_s.alu_src_b   = SRC_B_IMM_SH2;
        ctl_s.alu_op_main = ALU_OP_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R_TYPE:    state_d = S_RTEXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J: begin
            if (ENABLE_JUMP) begin
              state_d = S_JUMP;
            end else begin
              bad_op_s = 1'b1;
            end
          end
          default:      bad_op_s = 1'b1;
        endcase
        if (bad_op_s) begin
          if (TRAP_ON_ILLEGAL) begin
            state_d       = S_TRAP;
            illegal_set_s = 1'b1;
          end else begin
            // Treated as a NOP that still retires
            state_d          = S_FETCH;
            ctl_s.instr_done = 1'b1;
          end
        end else begin
          illegal_set_s = 1'b0;
        end
      end
      S_MEMADR: begin
        ctl_s.alu_src_a   = 1'b1;
        ctl_s.alu_src_b   = SRC_B_IMM;
        ctl_s.alu_op_main = ALU_OP_ADD;
        if (opcode == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMRD: begin
        ctl_s.mem_read = 1'b1;
        ctl_s.i_or_d   = 1'b1;
        if (ack_s) begin
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMWB: begin
        ctl_s.reg_write  = 1'b1;
        ctl_s.mem_to_reg = 1'b1;
        ctl_s.reg_dst    = 1'b0;
        ctl_s.instr_done = 1'b1;
        state_d          = S_FETCH;
      end
      S_MEMWR: begin
        ctl_s.mem_write  = 1'b1;
        ctl_s.i_or_d     = 1'b1;
        ctl_s.instr_done = ack_s;
        if (ack_s) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_RTEXEC: begin
        ctl_s.alu_src_a   = 1'b1;
        ctl_s.alu_src_b   = SRC_B_REG;
        ctl_s.alu_op_main = ALU_OP_RTYPE;
        state_d           = S_ALUWB;
      end
      S_ALUWB: begin
        ctl_s.reg_write  = 1'b1;
        ctl_s.reg_dst    = 1'b1;
        ctl_s.instr_done = 1'b1;
        state_d          = S_FETCH;
      end
      S_ADDIEXEC: begin
        ctl_s.alu_src_a   = 1'b1;
        ctl_s.alu_src_b   = SRC_B_IMM;
        ctl_s.alu_op_main = ALU_OP_ADD;
        state_d           = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctl_s.reg_write  = 1'b1;
        ctl_s.reg_dst    = 1'b0;
        ctl_s.instr_done = 1'b1;
        state_d          = S_FETCH;
      end
      S_BEQ: begin
        ctl_s.alu_src_a     = 1'b1;
        ctl_s.alu_src_b     = SRC_B_REG;
        ctl_s.alu_op_main   = ALU_OP_SUB;
        ctl_s.pc_write_cond = 1'b1;
        ctl_s.pc_source     = PC_SRC_ALUOUT;
        ctl_s.instr_done    = 1'b1;
        state_d             = S_FETCH;
      end
      S_JUMP: begin
        ctl_s.pc_write   = 1'b1;
        ctl_s.pc_source  = PC_SRC_JUMP;
        ctl_s.instr_done = 1'b1;
        state_d          = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        // Unreachable encodings restart cleanly
        state_d = S_RESET;
      end
    endcase
    // Watchdog expiry squashes every strobe in the trap cycle
    if (wd_trap_s) begin
      ctl_s   = CTL_IDLE;
      state_d = S_TRAP;
    end else begin
      ctl_s = ctl_s;
    end
  end

  // Sticky illegal flag and retired-instruction counter next values
  always_comb begin
    illegal_d = illegal_q | illegal_set_s;
    count_d   = count_q + {{(CNT_W-1){1'b0}}, ctl_s.instr_done};
  end

  // State register, sticky illegal flag and retired count
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RESET;
      illegal_q <= 1'b0;
      count_q   <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  assign pc_write      = ctl_s.pc_write;
  assign pc_write_cond = ctl_s.pc_write_cond;
  assign pc_source     = ctl_s.pc_source;
  assign i_or_d        = ctl_s.i_or_d;
  assign mem_read      = ctl_s.mem_read;
  assign mem_write     = ctl_s.mem_write;
  assign ir_write      = ctl_s.ir_write;
  assign reg_dst       = ctl_s.reg_dst;
  assign mem_to_reg    = ctl_s.mem_to_reg;
  assign reg_write     = ctl_s.reg_write;
  assign alu_src_a     = ctl_s.alu_src_a;
  assign alu_src_b     = ctl_s.alu_src_b;
  assign alu_op_main   = ctl_s.alu_op_main;
  assign instr_done    = ctl_s.instr_done;
  assign illegal_op    = illegal_q;
  assign instr_count   = count_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one DUT with a short memory
// watchdog, a second that treats illegal opcodes as NOPs.
module tb_multicycle_control;
  import mcu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        mem_ready;

  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done;
  logic        illegal_op, mem_timeout;
  logic [1:0]  pc_source, alu_src_b, alu_op_main;
  logic [31:0] instr_count;
  logic [3:0]  state_dbg;

  logic        pc_write_b, pc_write_cond_b, i_or_d_b, mem_read_b, mem_write_b, ir_write_b;
  logic        reg_dst_b, mem_to_reg_b, reg_write_b, alu_src_a_b, instr_done_b;
  logic        illegal_op_b, mem_timeout_b;
  logic [1:0]  pc_source_b, alu_src_b_b, alu_op_main_b;
  logic [31:0] instr_count_b;
  logic [3:0]  state_dbg_b;

  logic [16:0] ctl_a, ctl_b;
  int          n_assert = 0;
  int          n_fail   = 0;

  // Expected control words: pcw pwc psrc iord mrd mwr irw rdst m2r rw asa asb aop done
  localparam logic [16:0] C_ZERO   = 17'b0_0_00_0_0_0_0_0_0_0_0_00_00_0;
  localparam logic [16:0] C_F1     = 17'b1_0_00_0_1_0_1_0_0_0_0_01_00_0;
  localparam logic [16:0] C_F0     = 17'b0_0_00_0_1_0_0_0_0_0_0_01_00_0;
  localparam logic [16:0] C_DEC    = 17'b0_0_00_0_0_0_0_0_0_0_0_11_00_0;
  localparam logic [16:0] C_DEC_D  = 17'b0_0_00_0_0_0_0_0_0_0_0_11_00_1;
  localparam logic [16:0] C_MADR   = 17'b0_0_00_0_0_0_0_0_0_0_1_10_00_0;
  localparam logic [16:0] C_MRD    = 17'b0_0_00_1_1_0_0_0_0_0_0_00_00_0;
  localparam logic [16:0] C_MWB    = 17'b0_0_00_0_0_0_0_0_1_1_0_00_00_1;
  localparam logic [16:0] C_MWR0   = 17'b0_0_00_1_0_1_0_0_0_0_0_00_00_0;
  localparam logic [16:0] C_MWR1   = 17'b0_0_00_1_0_1_0_0_0_0_0_00_00_1;
  localparam logic [16:0] C_RTEX   = 17'b0_0_00_0_0_0_0_0_0_0_1_00_10_0;
  localparam logic [16:0] C_ALUWB  = 17'b0_0_00_0_0_0_0_1_0_1_0_00_00_1;
  localparam logic [16:0] C_ADDIWB = 17'b0_0_00_0_0_0_0_0_0_1_0_00_00_1;
  localparam logic [16:0] C_BEQ    = 17'b0_1_01_0_0_0_0_0_0_0_1_00_01_1;
  localparam logic [16:0] C_JMP    = 17'b1_0_10_0_0_0_0_0_0_0_0_00_00_1;

  assign ctl_a = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op_main, instr_done};
  assign ctl_b = {pc_write_b, pc_write_cond_b, pc_source_b, i_or_d_b, mem_read_b, mem_write_b,
                  ir_write_b, reg_dst_b, mem_to_reg_b, reg_write_b, alu_src_a_b, alu_src_b_b,
                  alu_op_main_b, instr_done_b};

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op_main(alu_op_main),
    .instr_done(instr_done), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
    .instr_count(instr_count), .state_dbg(state_dbg)
  );

  multicycle_control #(.TRAP_ON_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write_b), .pc_write_cond(pc_write_cond_b), .pc_source(pc_source_b),
    .i_or_d(i_or_d_b), .mem_read(mem_read_b), .mem_write(mem_write_b), .ir_write(ir_write_b),
    .reg_dst(reg_dst_b), .mem_to_reg(mem_to_reg_b), .reg_write(reg_write_b),
    .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b), .alu_op_main(alu_op_main_b),
    .instr_done(instr_done_b), .illegal_op(illegal_op_b), .mem_timeout(mem_timeout_b),
    .instr_count(instr_count_b), .state_dbg(state_dbg_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the main DUT mid-cycle, then advance to just after the next edge
  task automatic cyc(input string tag, input logic [3:0] st, input logic [16:0] ctl,
                     input logic [31:0] cnt);
    @(negedge clk);
    chk({tag, "/state"}, {28'd0, state_dbg}, {28'd0, st});
    chk({tag, "/ctl"}, {15'd0, ctl_a}, {15'd0, ctl});
    chk({tag, "/count"}, instr_count, cnt);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; opcode = OP_R_TYPE; mem_ready = 1'b1;
    @(posedge clk); #1;
    cyc("rst_hold", S_RESET, C_ZERO, 32'd0);
    rst = 1'b0;
    chk("rst_ill", {31'd0, illegal_op}, 32'd0);
    chk("rst_tmo", {31'd0, mem_timeout}, 32'd0);
    cyc("rst_rel", S_RESET, C_ZERO, 32'd0);

    // lw, zero wait: 5 cycles
    opcode = OP_LW;
    cyc("lw_f",   S_FETCH,  C_F1,   32'd0);
    cyc("lw_d",   S_DECODE, C_DEC,  32'd0);
    cyc("lw_a",   S_MEMADR, C_MADR, 32'd0);
    cyc("lw_rd",  S_MEMRD,  C_MRD,  32'd0);
    cyc("lw_wb",  S_MEMWB,  C_MWB,  32'd0);

    // sw with two wait cycles in MEMWR: 6 cycles
    opcode = OP_SW;
    cyc("sw_f",   S_FETCH,  C_F1,   32'd1);
    cyc("sw_d",   S_DECODE, C_DEC,  32'd1);
    cyc("sw_a",   S_MEMADR, C_MADR, 32'd1);
    mem_ready = 1'b0;
    cyc("sw_w1",  S_MEMWR,  C_MWR0, 32'd1);
    cyc("sw_w2",  S_MEMWR,  C_MWR0, 32'd1);
    mem_ready = 1'b1;
    cyc("sw_w3",  S_MEMWR,  C_MWR1, 32'd1);

    // R-type, addi, beq, j: 14 cycles
    opcode = OP_R_TYPE;
    cyc("r_f",    S_FETCH,    C_F1,     32'd2);
    cyc("r_d",    S_DECODE,   C_DEC,    32'd2);
    cyc("r_ex",   S_RTEXEC,   C_RTEX,   32'd2);
    cyc("r_wb",   S_ALUWB,    C_ALUWB,  32'd2);
    opcode = OP_ADDI;
    cyc("ai_f",   S_FETCH,    C_F1,     32'd3);
    cyc("ai_d",   S_DECODE,   C_DEC,    32'd3);
    cyc("ai_ex",  S_ADDIEXEC, C_MADR,   32'd3);
    cyc("ai_wb",  S_ADDIWB,   C_ADDIWB, 32'd3);
    opcode = OP_BEQ;
    cyc("bq_f",   S_FETCH,    C_F1,     32'd4);
    cyc("bq_d",   S_DECODE,   C_DEC,    32'd4);
    cyc("bq_ex",  S_BEQ,      C_BEQ,    32'd4);
    opcode = OP_J;
    cyc("j_f",    S_FETCH,    C_F1,     32'd5);
    cyc("j_d",    S_DECODE,   C_DEC,    32'd5);
    cyc("j_ex",   S_JUMP,     C_JMP,    32'd5);

    // lw interrupted by a 3-cycle reset while waiting in MEMRD
    opcode = OP_LW;
    cyc("rm_f",   S_FETCH,  C_F1,   32'd6);
    cyc("rm_d",   S_DECODE, C_DEC,  32'd6);
    cyc("rm_a",   S_MEMADR, C_MADR, 32'd6);
    mem_ready = 1'b0;
    cyc("rm_rd",  S_MEMRD,  C_MRD,  32'd6);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; mem_ready = 1'b1;
    cyc("rm_rst", S_RESET,  C_ZERO, 32'd0);

    // Illegal opcode: main DUT traps, dut_b retires it as a NOP
    opcode = 6'b111111;
    cyc("il_f",   S_FETCH,  C_F1,   32'd0);
    chk("ilb_dec", {15'd0, ctl_b}, {15'd0, C_DEC_D});
    cyc("il_d",   S_DECODE, C_DEC,  32'd0);
    for (int i = 0; i < 20; i++) begin
      if (i == 0) begin
        chk("ilb_state", {28'd0, state_dbg_b}, {28'd0, S_FETCH});
        chk("ilb_count", instr_count_b, 32'd1);
        chk("ilb_flag",  {31'd0, illegal_op_b}, 32'd0);
      end
      chk("il_flag", {31'd0, illegal_op}, 32'd1);
      cyc("il_trap", S_TRAP, C_ZERO, 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("il_clr", {31'd0, illegal_op}, 32'd0);
    cyc("il_rst", S_RESET, C_ZERO, 32'd0);

    // Watchdog: mem_ready stuck low in FETCH traps after 4 wait cycles
    opcode = OP_R_TYPE; mem_ready = 1'b0;
    cyc("to_w1", S_FETCH, C_F0, 32'd0);
    cyc("to_w2", S_FETCH, C_F0, 32'd0);
    cyc("to_w3", S_FETCH, C_F0, 32'd0);
    @(negedge clk);
    chk("to_w4", {28'd0, state_dbg}, {28'd0, S_FETCH});
    @(posedge clk); #1;
    chk("to_flag", {31'd0, mem_timeout}, 32'd1);
    chk("to_mrd",  {31'd0, mem_read}, 32'd0);
    cyc("to_trap1", S_TRAP, C_ZERO, 32'd0);
    mem_ready = 1'b1;
    cyc("to_trap2", S_TRAP, C_ZERO, 32'd0);

    // Same again but ack arrives on the 4th cycle: no trap
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0;
    chk("to_clr", {31'd0, mem_timeout}, 32'd0);
    cyc("na_rst", S_RESET, C_ZERO, 32'd0);
    cyc("na_w1",  S_FETCH, C_F0,   32'd0);
    cyc("na_w2",  S_FETCH, C_F0,   32'd0);
    cyc("na_w3",  S_FETCH, C_F0,   32'd0);
    mem_ready = 1'b1;
    cyc("na_ack", S_FETCH, C_F1,   32'd0);
    cyc("na_dec", S_DECODE, C_DEC, 32'd0);
    chk("na_flag", {31'd0, mem_timeout}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
